direct_mapped_line_cache: RTL and testbench

//   Read-only direct-mapped cache with multi-word lines and burst refill, sitting between a core fetch/load port
//   and a slower memory. Misses refill a whole line word-by-word; hits are served from local storage.

---
 rtl/direct_mapped_line_cache.sv | 148 ++++++++++++++
 tb/tb_direct_mapped_line_cache.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/direct_mapped_line_cache.sv
// Read-only direct-mapped cache with multi-word lines, burst refill and global line invalidate.
// Define CACHE_STATS_EN to add free-running hit/miss counters (hit_count_o, miss_count_o).
//
// state  | meaning
// IDLE   | waiting for a core request
// LOOKUP | tag/valid compare on the latched address
// REFILL | memory read of the current line word outstanding
// GAP    | one quiet cycle between refill words
module direct_mapped_line_cache #(
    parameter int CACHE_ENTRIES = 16,
    parameter int LINE_WORDS    = 4,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [31:0]           cache_rdata,
    input  logic                  cache_rstrb,
    output logic                  cache_done,
    input  logic                  invalidate_i,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic                  mem_rstrb,
    input  logic                  mem_done
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
`endif
);

    localparam int IDX_W = $clog2(CACHE_ENTRIES);
    localparam int WRD_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - WRD_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_GAP} state_t;
    state_t state, state_next;

    logic [ADDR_WIDTH-3:0]    req_addr;
    logic [WRD_W-1:0]         req_word;
    logic [WRD_W-1:0]         word_cnt;
    logic [IDX_W-1:0]         req_idx;
    logic [TAG_W-1:0]         req_tag;
    logic [CACHE_ENTRIES-1:0] valid;
    logic [TAG_W-1:0]         tag_mem   [CACHE_ENTRIES];
    logic [31:0]              line_data [CACHE_ENTRIES][LINE_WORDS];
    logic                     inv_pending;
    logic                     accept;
    logic                     lookup_hit;
    logic                     word_done;
    logic                     last_done;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^cache_addr[1:0];

    assign req_word   = req_addr[WRD_W-1:0];
    assign req_idx    = req_addr[IDX_W+WRD_W-1:WRD_W];
    assign req_tag    = req_addr[ADDR_WIDTH-3:IDX_W+WRD_W];
    assign mem_addr   = {req_tag, req_idx, word_cnt, 2'b00};

    // An invalidate arriving in the LOOKUP cycle forces a miss.
    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !invalidate_i;
    assign word_done  = (state == S_REFILL) && mem_done;
    assign last_done  = word_done && (word_cnt == WRD_W'(LINE_WORDS - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mem_rstrb  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cache_rstrb && !cache_done) begin
                    accept     = 1'b1;
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: state_next = lookup_hit ? S_IDLE : S_REFILL;
            S_REFILL: begin
                mem_rstrb = 1'b1;
                if (mem_done) state_next = last_done ? S_IDLE : S_GAP;
            end
            S_GAP:    state_next = S_REFILL;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_addr    <= '0;
            word_cnt    <= '0;
            cache_done  <= 1'b0;
            cache_rdata <= '0;
            valid       <= '0;
            inv_pending <= 1'b0;
        end else begin
            cache_done <= 1'b0;
            if (accept) req_addr <= cache_addr[ADDR_WIDTH-1:2];
            if (state == S_LOOKUP) begin
                word_cnt <= '0;
                if (lookup_hit) begin
                    cache_done  <= 1'b1;
                    cache_rdata <= line_data[req_idx][req_word];
                end
            end
            if (word_done) begin
                if (word_cnt == req_word) cache_rdata <= mem_rdata;
                if (last_done) begin
                    cache_done  <= 1'b1;
                    inv_pending <= 1'b0;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
            // A refill overlapped by an invalidate still returns data but never validates its line.
            if (invalidate_i) begin
                valid <= '0;
                if (((state == S_REFILL) && !last_done) || (state == S_GAP)) inv_pending <= 1'b1;
            end else if (last_done && !inv_pending) begin
                valid[req_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && word_done) begin
            line_data[req_idx][word_cnt] <= mem_rdata;
            if (last_done) tag_mem[req_idx] <= req_tag;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else if (state == S_LOOKUP) begin
            if (lookup_hit) hit_count_o  <= hit_count_o + 32'd1;
            else            miss_count_o <= miss_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_direct_mapped_line_cache.sv
// Scoreboard bench for direct_mapped_line_cache: directed reads against a 3-cycle-latency memory model
// returning addr^32'hA5A5_0000; expected data/latency queued by the driver, checked by monitors.
module tb_direct_mapped_line_cache;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] cache_addr;
    logic [31:0] cache_rdata;
    logic        cache_rstrb;
    logic        cache_done;
    logic        invalidate_i;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rstrb;
    logic        mem_done;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;
`endif

    typedef struct {
        logic [31:0] data;
        int          done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_exp_q[$];
    exp_t        mon_e;
    logic [31:0] mem_ea;
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          busy_cnt = 0;
    int          exp_hit  = 0;
    int          exp_miss = 0;

    direct_mapped_line_cache dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cache_addr   (cache_addr),
        .cache_rdata  (cache_rdata),
        .cache_rstrb  (cache_rstrb),
        .cache_done   (cache_done),
        .invalidate_i (invalidate_i),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_rstrb    (mem_rstrb),
        .mem_done     (mem_done)
`ifdef CACHE_STATS_EN
        ,
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: mem_done on the third consecutive cycle of mem_rstrb.
    always @(negedge clk) begin
        mem_done = 1'b0;
        if (rst_i || !mem_rstrb) begin
            busy_cnt = 0;
        end else begin
            busy_cnt++;
            if (busy_cnt == 3) begin
                busy_cnt  = 0;
                mem_done  = 1'b1;
                mem_rdata = mem_addr ^ 32'hA5A5_0000;
                checks++;
                if (mem_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_unexpected: read at %h, required no memory read", mem_addr);
                end else begin
                    mem_ea = mem_exp_q.pop_front();
                    if (mem_addr !== mem_ea) begin
                        errors++;
                        $display("FAIL mem_addr: got %h, required %h", mem_addr, mem_ea);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cache_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: cache_done=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (cache_rdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL rdata: got %h, required %h", cache_rdata, mon_e.data);
                end
                checks++;
                if (cyc != mon_e.done_cyc) begin
                    errors++;
                    $display("FAIL done_cycle: got %0d, required %0d", cyc, mon_e.done_cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // inv_at: cycle offset after request (0 = none) at which invalidate_i pulses.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input bit hit, input int inv_at);
        int   n;
        bit   seen;
        exp_t e;
        @(negedge clk);
        n          = cyc;
        e.data     = exp_data;
        e.done_cyc = n + (hit ? 2 : 17);
        exp_q.push_back(e);
        if (!hit) begin
            for (int i = 0; i < 4; i++) mem_exp_q.push_back({addr[31:4], 4'h0} + 32'(4 * i));
            exp_miss++;
        end else begin
            exp_hit++;
        end
        cache_addr  = addr;
        cache_rstrb = 1'b1;
        seen        = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            invalidate_i = (k == inv_at);
            if (k == 2) cache_addr = ~addr;
            if (cache_done) seen = 1'b1;
        end
        cache_rstrb  = 1'b0;
        invalidate_i = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: no cache_done within 40 cycles for %h, required one", addr);
        end
    endtask

    task automatic reset_mid_refill(input logic [31:0] addr);
        @(negedge clk);
        cache_addr  = addr;
        cache_rstrb = 1'b1;
        repeat (3) @(negedge clk);
        rst_i       = 1'b1;
        cache_rstrb = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_rstrb", {31'd0, mem_rstrb}, 32'd0);
        chk("rst_mid_cache_done", {31'd0, cache_done}, 32'd0);
        chk("rst_mid_mem_addr", mem_addr, 32'd0);
        rst_i    = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst_i        = 1'b1;
        cache_addr   = '0;
        cache_rstrb  = 1'b0;
        invalidate_i = 1'b0;
        mem_rdata    = '0;
        mem_done     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cache_done", {31'd0, cache_done}, 32'd0);
        chk("reset_cache_rdata", cache_rdata, 32'd0);
        chk("reset_mem_rstrb", {31'd0, mem_rstrb}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        rst_i = 1'b0;

        do_read(32'h0000_0100, 32'hA5A5_0100, 1'b0, 0);
        do_read(32'h0000_0108, 32'hA5A5_0108, 1'b1, 0);
        do_read(32'h0000_0200, 32'hA5A5_0200, 1'b0, 0);
        do_read(32'h0000_0100, 32'hA5A5_0100, 1'b0, 0);
        do_read(32'h0000_0104, 32'hA5A5_0104, 1'b1, 0);
        do_read(32'h0000_034C, 32'hA5A5_034C, 1'b0, 0);
        do_read(32'h0000_0340, 32'hA5A5_0340, 1'b1, 0);
        do_read(32'h0000_0208, 32'hA5A5_0208, 1'b0, 6);
        do_read(32'h0000_0208, 32'hA5A5_0208, 1'b0, 0);
        do_read(32'h0000_0344, 32'hA5A5_0344, 1'b0, 0);

        reset_mid_refill(32'h0000_0400);
        do_read(32'h0000_0400, 32'hA5A5_0400, 1'b0, 0);
        do_read(32'h0000_040C, 32'hA5A5_040C, 1'b1, 0);
        @(negedge clk);
        invalidate_i = 1'b1;
        @(negedge clk);
        invalidate_i = 1'b0;
        do_read(32'h0000_040C, 32'hA5A5_040C, 1'b0, 0);
        do_read(32'h0000_0404, 32'hA5A5_0404, 1'b0, 1);

        repeat (8) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("mem_q_drained", 32'(mem_exp_q.size()), 32'd0);
`ifdef CACHE_STATS_EN
        chk("hit_count", hit_count_o, 32'(exp_hit));
        chk("miss_count", miss_count_o, 32'(exp_miss));
        @(negedge clk);
        invalidate_i = 1'b1;
        @(negedge clk);
        invalidate_i = 1'b0;
        @(negedge clk);
        chk("hit_count_after_inv", hit_count_o, 32'(exp_hit));
        chk("miss_count_after_inv", miss_count_o, 32'(exp_miss));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
